// File: rtl/rf_wb_arbiter_if.sv
// Request bundle between the two write-port producers and the register-file arbiter.
// The producers use the master modport. The arbiter uses the slave modport.
interface rf_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  b_ready
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output b_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback (A) has fixed priority over the
// multi-cycle unit (B). A starvation guard freezes A so that B can write.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rf_wb_arbiter_if.slave wb,
    output logic        stall_req,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic [31:0] write_Data,
    output logic        proto_err
);

    localparam int unsigned          NPORT = 2;
    localparam logic [CNT_W-1:0]     LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_STALL  = 1'b1
    } state_t;

    // Index 0 is port A and has the highest priority. Index 1 is port B.
    logic [NPORT-1:0] req_valid;
    logic [4:0]       req_rd   [NPORT];
    logic [31:0]      req_data [NPORT];
    logic [NPORT-1:0] live;
    logic [NPORT-1:0] grant;

    assign req_valid[0] = wb.a_valid;
    assign req_rd[0]    = wb.a_rd;
    assign req_data[0]  = wb.a_data;
    assign req_valid[1] = wb.b_valid;
    assign req_rd[1]    = wb.b_rd;
    assign req_data[1]  = wb.b_data;

    // A write to x0 is consumed but never reaches the register file.
    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_live
            assign live[gi] = req_valid[gi] && (req_rd[gi] != 5'd0);
        end
    endgenerate

    assign grant[0] = live[0];
    assign grant[1] = live[1] && !live[0];

    logic b_xfer;
    assign wb.b_ready = !live[0];
    assign b_xfer     = wb.b_valid && wb.b_ready;

    // Starvation counter.
    logic [CNT_W-1:0] starv_reg;
    logic [CNT_W-1:0] starv_next;

    always_comb begin
        starv_next = starv_reg;
        if (!wb.b_valid || b_xfer) begin
            starv_next = '0;
        end else if (starv_reg < LIMIT) begin
            starv_next = starv_reg + 1'b1;
        end
    end

    // Stall FSM.
    state_t state_reg;
    state_t state_next;
    logic   proto_set;

    always_comb begin
        state_next = state_reg;
        proto_set  = 1'b0;
        case (state_reg)
            ST_NORMAL: begin
                if (starv_next == LIMIT) begin
                    state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                // A live write here is still granted. It is only flagged.
                if (live[0]) begin
                    proto_set = 1'b1;
                end
                if (b_xfer) begin
                    state_next = ST_NORMAL;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    // Next values for the output stage. With no grant, the address and data hold their values.
    logic        wr_en_next;
    logic [4:0]  wr_rd_next;
    logic [31:0] wr_data_next;
    logic        wr_en_reg;
    logic [4:0]  wr_rd_reg;
    logic [31:0] wr_data_reg;
    logic        proto_reg;

    always_comb begin
        wr_en_next   = 1'b0;
        wr_rd_next   = wr_rd_reg;
        wr_data_next = wr_data_reg;
        if (grant[0]) begin
            wr_en_next   = 1'b1;
            wr_rd_next   = req_rd[0];
            wr_data_next = req_data[0];
        end else if (grant[1]) begin
            wr_en_next   = 1'b1;
            wr_rd_next   = req_rd[1];
            wr_data_next = req_data[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_NORMAL;
            starv_reg   <= '0;
            wr_en_reg   <= 1'b0;
            wr_rd_reg   <= 5'd0;
            wr_data_reg <= 32'd0;
            proto_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            starv_reg   <= starv_next;
            wr_en_reg   <= wr_en_next;
            wr_rd_reg   <= wr_rd_next;
            wr_data_reg <= wr_data_next;
            proto_reg   <= proto_reg | proto_set;
        end
    end

    assign stall_req  = (state_reg == ST_STALL);
    assign regWrite   = wr_en_reg;
    assign rd         = wr_rd_reg;
    assign write_Data = wr_data_reg;
    assign proto_err  = proto_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vectors for rf_wb_arbiter with STARVE_LIMIT=4: grant priority, discarding writes
// to x0, the starvation stall, sticky proto_err, and asynchronous reset in the middle of a stall.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall_req;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] write_Data;
    logic        proto_err;

    rf_wb_arbiter_if wb_if ();

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb_if),
        .stall_req  (stall_req),
        .regWrite   (regWrite),
        .rd         (rd),
        .write_Data (write_Data),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        e_br;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_st;
        logic        e_pe;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        wb_if.a_valid = av;
        wb_if.a_rd    = ard;
        wb_if.a_data  = ad;
        wb_if.b_valid = bv;
        wb_if.b_rd    = brd;
        wb_if.b_data  = bd;
    endtask

    task automatic chk_out(input string tag, input logic rw, input logic [4:0] erd,
                           input logic [31:0] wd, input logic st, input logic pe);
        chk({tag, ".regWrite"},   32'(regWrite),   32'(rw));
        chk({tag, ".rd"},         32'(rd),         32'(erd));
        chk({tag, ".write_Data"}, write_Data,      wd);
        chk({tag, ".stall_req"},  32'(stall_req),  32'(st));
        chk({tag, ".proto_err"},  32'(proto_err),  32'(pe));
    endtask

    initial begin
        // Each vector is one cycle. b_ready is checked combinationally, and the outputs after the edge.
        vecs[0]  = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 5'd5,  32'h1234, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd5,  32'h1234, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd3,  32'hAA,   1'b1, 5'd7,  32'hBB, 1'b0, 1'b1, 5'd3,  32'hAA,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'hBB, 1'b1, 1'b1, 5'd7,  32'hBB,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hCC, 1'b1, 1'b0, 5'd7,  32'hBB,   1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd0,  32'hDD,   1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd7,  32'hBB,   1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd1,  32'h11,   1'b1, 5'd10, 32'h55, 1'b0, 1'b1, 5'd1,  32'h11,   1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd2,  32'h22,   1'b1, 5'd10, 32'h55, 1'b0, 1'b1, 5'd2,  32'h22,   1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd3,  32'h33,   1'b1, 5'd10, 32'h55, 1'b0, 1'b1, 5'd3,  32'h33,   1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd4,  32'h44,   1'b1, 5'd10, 32'h55, 1'b0, 1'b1, 5'd4,  32'h44,   1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd9,  32'h99,   1'b1, 5'd10, 32'h55, 1'b0, 1'b1, 5'd9,  32'h99,   1'b1, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 32'h55, 1'b1, 1'b1, 5'd10, 32'h55,   1'b0, 1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd10, 32'h55,   1'b0, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #3;
        chk("reset.b_ready", 32'(wb_if.b_ready), 32'd1);
        chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        $display("reset: regWrite=%0b rd=%0d stall=%0b", regWrite, rd, stall_req);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd);
            #1;
            chk($sformatf("v%0d.b_ready", i), 32'(wb_if.b_ready), 32'(vecs[i].e_br));
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].e_rw, vecs[i].e_rd, vecs[i].e_wd,
                    vecs[i].e_st, vecs[i].e_pe);
            $display("v%0d: a=%0b/%0d b=%0b/%0d -> regWrite=%0b rd=%0d data=%0h stall=%0b perr=%0b",
                     i, vecs[i].av, vecs[i].ard, vecs[i].bv, vecs[i].brd,
                     regWrite, rd, write_Data, stall_req, proto_err);
        end

        // Build a stall again. Keep A live with B pending for four cycles.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(k + 16), 32'(k * 16'h100), 1'b1, 5'd12, 32'h77);
            @(posedge clk);
            #1;
        end
        chk("pre_rst.stall_req", 32'(stall_req), 32'd1);
        chk("pre_rst.regWrite", 32'(regWrite), 32'd1);
        chk("pre_rst.rd", 32'(rd), 32'd20);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        $display("mid-stall reset: stall=%0b regWrite=%0b perr=%0b", stall_req, regWrite, proto_err);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.b_ready", 32'(wb_if.b_ready), 32'd0);
        chk("post_rst.stall_req", 32'(stall_req), 32'd0);

        // The counter restarts from 0, so the stall must rise exactly four cycles after release.
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            drive(1'b1, 5'(k), 32'(k), 1'b1, 5'd12, 32'h77);
            @(posedge clk);
            #1;
            chk($sformatf("restart%0d.stall_req", k), 32'(stall_req), 32'(k == 4));
            chk($sformatf("restart%0d.rd", k), 32'(rd), 32'(k));
            $display("restart cycle %0d: stall=%0b rd=%0d", k, stall_req, rd);
        end

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h77);
        #1;
        chk("drain.b_ready", 32'(wb_if.b_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_out("drain", 1'b1, 5'd12, 32'h77, 1'b0, 1'b0);
        $display("drain: regWrite=%0b rd=%0d data=%0h stall=%0b", regWrite, rd, write_Data, stall_req);

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("idle.regWrite", 32'(regWrite), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the 32x32 register file. Two producers compete for the single write port: the in-order pipeline writeback (port A) and a multi-cycle unit such as a divider or load-miss return (port B). Port A cannot be back-pressured, so it has priority. Port B uses valid/ready, and a starvation guard raises a stall request toward the hazard unit. The block drives the register file's regWrite/rd/write_Data through a registered output stage.

## Interface
- STARVE_LIMIT, 4: consecutive stalled cycles of a pending B request before stall_req asserts; legal range 1..255.
- CNT_W, 8: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  pipeline writeback request; never back-pressured.
- a_rd  input  5  destination register for A.
- a_data  input  32  write data for A.
- b_valid  input  1  multi-cycle unit request; held until accepted.
- b_rd  input  5  destination register for B.
- b_data  input  32  write data for B.
- b_ready  output  1  combinational accept for B.
- stall_req  output  1  registered request to the hazard unit to freeze the stage feeding A.
- regWrite  output  1  registered write enable to the register file.
- rd  output  5  registered write address.
- write_Data  output  32  registered write data.
- proto_err  output  1  sticky flag: A fired while stall_req was high.

## Operation
- A is live when a_valid=1 and a_rd≠0.
- B is live when b_valid=1 and b_rd≠0.
- Grant, evaluated each cycle:
  - If A is live, grant A.
  - Otherwise, if B is live, grant B.
  - Otherwise, grant none.
- b_ready = !(A live). When b_valid=1 and b_rd=0, B is accepted, or when a_valid=1 and a_rd=0, A is consumed; in both cases the write is discarded, with no regWrite pulse and no slot used.
- Handshake: B transfers on b_valid && b_ready. While b_valid=1 and b_ready=0, b_rd and b_data must hold stable. The arbiter does not check this.
- Starvation counter starv:
  - Increments on a cycle with b_valid=1 and b_ready=0, saturating at STARVE_LIMIT.
  - Clears on any B transfer or when b_valid=0.
- stall_req FSM, two states:
  - NORMAL → STALL when starv reaches STARVE_LIMIT at the clock edge.
  - STALL → NORMAL on the edge following a B transfer.
  - stall_req = (state==STALL).
- In STALL the hazard unit guarantees a_valid=0, so B wins the next cycle. If A is nonetheless live in STALL, A still wins (a pipeline write is never lost), proto_err sets and stays set until reset, and the FSM remains in STALL.
- Output stage: each cycle the granted request's rd/data is captured, with regWrite=1. With no grant, regWrite=0, and rd/write_Data hold their previous values.
- Same-register writes from A and B are not merged. Ordering is grant order; the later-granted value ends up in the register.

## Timing
- Reset values, applied asynchronously and immediately:
  - regWrite=0, rd=0, write_Data=0, stall_req=0, proto_err=0.
  - starv=0, state=NORMAL.
  - b_ready follows its combinational equation.
- Latency: a request granted in cycle N appears on regWrite/rd/write_Data in cycle N+1. The register file commits at the end of cycle N+1.
- Throughput: one write per cycle.
- B worst case: with A live every cycle, stall_req rises STARVE_LIMIT cycles after b_valid first goes high with b_ready=0. B is granted the first cycle A is held off.
- Reset during STALL: the FSM returns to NORMAL, and any pending B is abandoned by the arbiter. The B unit's own reset handles its side.
- Reset released mid-request: starv restarts from 0.

## Test plan
- A only: a_valid=1, a_rd=5, a_data=0x1234 for one cycle → next cycle regWrite=1, rd=5, write_Data=0x1234; the following cycle regWrite=0.
- Simultaneous A and B: a_rd=3/0xAA and b_rd=7/0xBB in the same cycle → b_ready=0, write rd=3 first; B held, b_ready=1 when A drops, then write rd=7 with 0xBB.
- Zero register: b_valid=1, b_rd=0 → b_ready=1, B accepted, no regWrite pulse; same for a_rd=0.
- Starvation with STARVE_LIMIT=4: A live every cycle with b_valid=1 → stall_req=1 after 4 cycles. Drop a_valid → B granted, its write appears next cycle, stall_req=0 the cycle after the transfer.
- Protocol violation: a_valid=1, a_rd=9 while stall_req=1 → rd=9 written, proto_err=1 and sticky, stall_req stays 1 until B transfers.
- Reset mid-stall: assert rst_n=0 with stall_req=1 and regWrite=1 → all outputs 0 immediately; after release, state=NORMAL and starv=0.
